// File: rtl/sonic_rx_blocksync.sv
// sonic_rx_blocksync: receive gearbox turning the 40-bit transceiver word
// stream into 66-bit blocks, plus the sync-header lock search that bit-slips
// the gearbox until block boundaries line up with the transmitter.
module sonic_rx_blocksync #(
    parameter int SH_CNT_MAX   = 64,
    parameter int SH_INVLD_MAX = 16,
    parameter int SLIP_HOLD    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_ready,
    input  logic [39:0] data_in,
    output logic [65:0] data_out,
    output logic        data_valid,
    output logic        lock,
    output logic [15:0] slip_count
);

    localparam logic [1:0] ST_RESET_CNT = 2'd0;
    localparam logic [1:0] ST_TEST_SH   = 2'd1;
    localparam logic [1:0] ST_SLIP      = 2'd2;

    localparam logic [6:0] BLK_BITS     = 7'd66;
    localparam logic [6:0] WORD_BITS    = 7'd40;
    localparam logic [6:0] SH_CNT_LIM   = 7'(SH_CNT_MAX);
    localparam logic [4:0] SH_INVLD_LIM = 5'(SH_INVLD_MAX);
    localparam logic [1:0] HOLD_INIT    = 2'(SLIP_HOLD);

    // A sync header is valid exactly when its two bits differ.
    function automatic logic sh_is_valid(input logic [1:0] sh);
        return sh[1] ^ sh[0];
    endfunction

    // Registered state
    logic [105:0] gear_r;
    logic [6:0]   fill_r;
    logic         slip_pend_r;
    logic [1:0]   state_r;
    logic [6:0]   sh_cnt_r;
    logic [4:0]   sh_invld_r;
    logic [1:0]   hold_cnt_r;

    // Combinational next-state terms
    logic         emit_s;
    logic [65:0]  blk_s;
    logic         sh_bad_s;
    logic [105:0] gear_a_s;
    logic [6:0]   fill_a_s;
    logic [6:0]   base_cnt_s;
    logic [4:0]   base_invld_s;
    logic [6:0]   cnt_inc_s;
    logic [4:0]   invld_inc_s;
    logic [1:0]   state_nx_s;
    logic [6:0]   sh_cnt_nx_s;
    logic [4:0]   sh_invld_nx_s;
    logic [1:0]   hold_nx_s;
    logic         lock_nx_s;
    logic         slip_req_s;
    logic         slip_do_s;
    logic         slip_pend_nx_s;
    logic [105:0] gear_b_s;
    logic [6:0]   fill_b_s;
    logic [105:0] gear_c_s;
    logic [6:0]   fill_c_s;

    // Step (a): pull a complete block off the bottom of the gearbox.
    always_comb begin
        emit_s   = (fill_r >= BLK_BITS);
        blk_s    = gear_r[65:0];
        sh_bad_s = ~sh_is_valid(gear_r[1:0]);
        if (emit_s) begin
            gear_a_s = {66'd0, gear_r[105:66]};
            fill_a_s = fill_r - BLK_BITS;
        end else begin
            gear_a_s = gear_r;
            fill_a_s = fill_r;
        end
    end

    // Lock search: evaluates each emitted block on the edge it is registered.
    always_comb begin
        state_nx_s    = state_r;
        sh_cnt_nx_s   = sh_cnt_r;
        sh_invld_nx_s = sh_invld_r;
        hold_nx_s     = hold_cnt_r;
        lock_nx_s     = lock;
        slip_req_s    = 1'b0;
        // RESET_CNT presents zeroed counters so a block arriving in that
        // state already counts as the first of the new window.
        if (state_r == ST_RESET_CNT) begin
            base_cnt_s   = 7'd0;
            base_invld_s = 5'd0;
        end else begin
            base_cnt_s   = sh_cnt_r;
            base_invld_s = sh_invld_r;
        end
        cnt_inc_s   = base_cnt_s + 7'd1;
        invld_inc_s = base_invld_s + {4'd0, sh_bad_s};
        case (state_r)
            ST_RESET_CNT, ST_TEST_SH: begin
                if (emit_s) begin
                    sh_cnt_nx_s   = cnt_inc_s;
                    sh_invld_nx_s = invld_inc_s;
                    if (!lock) begin
                        if (sh_bad_s) begin
                            slip_req_s = 1'b1;
                            hold_nx_s  = HOLD_INIT;
                            state_nx_s = ST_SLIP;
                        end else if (cnt_inc_s == SH_CNT_LIM) begin
                            lock_nx_s  = 1'b1;
                            state_nx_s = ST_RESET_CNT;
                        end else begin
                            state_nx_s = ST_TEST_SH;
                        end
                    end else begin
                        if (invld_inc_s == SH_INVLD_LIM) begin
                            lock_nx_s  = 1'b0;
                            slip_req_s = 1'b1;
                            hold_nx_s  = HOLD_INIT;
                            state_nx_s = ST_SLIP;
                        end else if (cnt_inc_s == SH_CNT_LIM) begin
                            state_nx_s = ST_RESET_CNT;
                        end else begin
                            state_nx_s = ST_TEST_SH;
                        end
                    end
                end else begin
                    sh_cnt_nx_s   = base_cnt_s;
                    sh_invld_nx_s = base_invld_s;
                    state_nx_s    = ST_TEST_SH;
                end
            end
            ST_SLIP: begin
                // Blocks right after a slip straddle the old alignment; skip them.
                if (hold_cnt_r == 2'd0) begin
                    state_nx_s = ST_RESET_CNT;
                end else if (emit_s) begin
                    hold_nx_s = hold_cnt_r - 2'd1;
                    if (hold_cnt_r == 2'd1) begin
                        state_nx_s = ST_RESET_CNT;
                    end else begin
                        state_nx_s = ST_SLIP;
                    end
                end else begin
                    state_nx_s = ST_SLIP;
                end
            end
            default: begin
                state_nx_s = ST_RESET_CNT;
            end
        endcase
    end

    // Steps (b) and (c): drop one bit for a slip, then append the new word.
    always_comb begin
        // A slip needs a bit in the buffer; with none left it waits a cycle.
        slip_do_s = (slip_pend_r | slip_req_s) & (fill_a_s != 7'd0);
        if (slip_do_s) begin
            gear_b_s       = {1'b0, gear_a_s[105:1]};
            fill_b_s       = fill_a_s - 7'd1;
            slip_pend_nx_s = 1'b0;
        end else begin
            gear_b_s       = gear_a_s;
            fill_b_s       = fill_a_s;
            slip_pend_nx_s = slip_pend_r | slip_req_s;
        end
        if (rx_ready) begin
            gear_c_s = gear_b_s | ({66'd0, data_in} << fill_b_s);
            fill_c_s = fill_b_s + WORD_BITS;
        end else begin
            gear_c_s = gear_b_s;
            fill_c_s = fill_b_s;
        end
    end

    // State and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            gear_r      <= 106'd0;
            fill_r      <= 7'd0;
            slip_pend_r <= 1'b0;
            state_r     <= ST_RESET_CNT;
            sh_cnt_r    <= 7'd0;
            sh_invld_r  <= 5'd0;
            hold_cnt_r  <= 2'd0;
            data_out    <= 66'd0;
            data_valid  <= 1'b0;
            lock        <= 1'b0;
            slip_count  <= 16'd0;
        end else begin
            gear_r      <= gear_c_s;
            fill_r      <= fill_c_s;
            slip_pend_r <= slip_pend_nx_s;
            state_r     <= state_nx_s;
            sh_cnt_r    <= sh_cnt_nx_s;
            sh_invld_r  <= sh_invld_nx_s;
            hold_cnt_r  <= hold_nx_s;
            lock        <= lock_nx_s;
            data_valid  <= emit_s;
            if (emit_s) begin
                data_out <= blk_s;
            end else begin
                data_out <= data_out;
            end
            if (slip_do_s && (slip_count != 16'hFFFF)) begin
                slip_count <= slip_count + 16'd1;
            end else begin
                slip_count <= slip_count;
            end
        end
    end

endmodule

// File: tb/tb_sonic_rx_blocksync.sv
// tb_sonic_rx_blocksync: randomized stimulus against a bit-queue reference
// model of the receive gearbox and lock search.
module tb_sonic_rx_blocksync;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx_ready;
    logic [39:0] data_in;
    logic [65:0] data_out;
    logic        data_valid;
    logic        lock;
    logic [15:0] slip_count;

    always #5 clock = ~clock;

    sonic_rx_blocksync dut (
        .clock      (clock),
        .reset      (reset),
        .rx_ready   (rx_ready),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .lock       (lock),
        .slip_count (slip_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- source generator ----------------
    bit          gen_q[$];
    bit          sent_log[$];
    logic [65:0] src_blk[$];
    int          gen_idx;
    bit          bad_set[int];
    bit          off_stream[$];
    logic [65:0] off_blocks[$];

    task automatic gen_restart();
        gen_q.delete();
        sent_log.delete();
        src_blk.delete();
        bad_set.delete();
        gen_idx = 0;
    endtask

    task automatic gen_block();
        logic [65:0] b;
        b[65:34] = $urandom;
        b[33:2]  = $urandom;
        b[1:0]   = gen_idx[0] ? 2'b10 : 2'b01;
        if (bad_set.exists(gen_idx)) begin
            b[1:0] = ($urandom_range(1, 0) == 0) ? 2'b00 : 2'b11;
        end
        src_blk.push_back(b);
        for (int i = 0; i < 66; i++) gen_q.push_back(b[i]);
        gen_idx++;
    endtask

    task automatic next_word(output logic [39:0] w);
        for (int i = 0; i < 40; i++) begin
            if (gen_q.size() == 0) gen_block();
            w[i] = gen_q.pop_front();
            sent_log.push_back(w[i]);
        end
    endtask

    // ---------------- reference model ----------------
    bit          mq[$];
    logic [65:0] m_data;
    bit          m_valid, m_lock, m_pend;
    int          m_skip, m_seen, m_bad;
    logic [15:0] m_slips;

    task automatic model_reset();
        mq.delete();
        m_data  = 66'd0;
        m_valid = 1'b0;
        m_lock  = 1'b0;
        m_pend  = 1'b0;
        m_skip  = 0;
        m_seen  = 0;
        m_bad   = 0;
        m_slips = 16'd0;
    endtask

    task automatic model_slip();
        m_pend = 1'b1;
        m_skip = 2;
        m_seen = 0;
        m_bad  = 0;
    endtask

    task automatic model_block(input logic [65:0] b);
        bit hdr_bad;
        hdr_bad = (b[1:0] == 2'b00) || (b[1:0] == 2'b11);
        if (m_skip > 0) begin
            m_skip--;
        end else begin
            m_seen++;
            if (hdr_bad) m_bad++;
            if (!m_lock) begin
                if (hdr_bad) model_slip();
                else if (m_seen == 64) begin m_lock = 1'b1; m_seen = 0; m_bad = 0; end
            end else begin
                if (m_bad == 16) begin m_lock = 1'b0; model_slip(); end
                else if (m_seen == 64) begin m_seen = 0; m_bad = 0; end
            end
        end
    endtask

    task automatic model_edge(input bit rdy, input logic [39:0] w);
        logic [65:0] b;
        m_valid = 1'b0;
        if (mq.size() >= 66) begin
            for (int i = 0; i < 66; i++) b[i] = mq.pop_front();
            m_valid = 1'b1;
            m_data  = b;
            model_block(b);
        end
        if (m_pend && mq.size() >= 1) begin
            void'(mq.pop_front());
            m_pend = 1'b0;
            if (m_slips != 16'hFFFF) m_slips++;
        end
        if (rdy) for (int i = 0; i < 40; i++) mq.push_back(w[i]);
    endtask

    // ---------------- drivers ----------------
    int          blk_cnt;
    int          lock_at;
    logic [15:0] slips_at_lock;
    logic [65:0] last_blk;

    task automatic step(input bit rdy);
        logic [39:0] w;
        logic [63:0] r;
        r = {$urandom, $urandom};
        if (rdy) next_word(w);
        else w = r[39:0];
        rx_ready = rdy;
        data_in  = w;
        @(posedge clock);
        model_edge(rdy, w);
        #1;
        check("valid", {65'd0, data_valid}, {65'd0, m_valid});
        check("data", data_out, m_data);
        check("lock", {65'd0, lock}, {65'd0, m_lock});
        check("slips", {50'd0, slip_count}, {50'd0, m_slips});
        if (data_valid) begin
            blk_cnt++;
            last_blk = data_out;
            if (lock && lock_at < 0) begin
                lock_at       = blk_cnt;
                slips_at_lock = slip_count;
            end
        end
    endtask

    task automatic do_reset();
        logic [63:0] r;
        r        = {$urandom, $urandom};
        reset    = 1'b0;
        rx_ready = 1'b0;
        data_in  = r[39:0];
        @(posedge clock);
        model_reset();
        #1;
        check("rst_valid", {65'd0, data_valid}, 66'd0);
        check("rst_lock", {65'd0, lock}, 66'd0);
        check("rst_slips", {50'd0, slip_count}, 66'd0);
        check("rst_data", data_out, 66'd0);
        reset   = 1'b1;
        blk_cnt = 0;
        lock_at = -1;
    endtask

    initial begin
        int          n, k, last_bad, lock_at_b;
        logic [15:0] slips_b;
        logic [65:0] e;
        reset    = 1'b0;
        rx_ready = 1'b0;
        data_in  = 40'd0;
        blk_cnt  = 0;
        lock_at  = -1;
        last_blk = 66'd0;

        // Aligned stream, then 15 bad headers in one window, 16 in the next.
        do_reset();
        gen_restart();
        n = 0;
        while (n < 15) begin
            k = $urandom_range(127, 64);
            if (!bad_set.exists(k)) begin bad_set[k] = 1'b1; n++; end
        end
        n = 0;
        last_bad = 0;
        while (n < 16) begin
            k = $urandom_range(191, 128);
            if (!bad_set.exists(k)) begin
                bad_set[k] = 1'b1;
                n++;
                if (k > last_bad) last_bad = k;
            end
        end
        for (int c = 0; c < 34; c++) step(1'b1);
        check("blocks_per_33_words", 66'(blk_cnt), 66'd20);
        check("aligned_first_blocks", last_blk, src_blk[19]);
        for (int c = 0; c < 400 && blk_cnt < 200; c++) begin
            step(1'b1);
            if (data_valid && blk_cnt == 128) begin
                check("lock_after_15_bad", {65'd0, lock}, 66'd1);
                check("slips_after_15_bad", {50'd0, slip_count}, 66'd0);
            end
            if (data_valid && blk_cnt == last_bad + 1) begin
                check("lock_drop_16th_bad", {65'd0, lock}, 66'd0);
                step(1'b1);
                check("slip_after_16th_bad", {50'd0, slip_count}, 66'd1);
            end
        end
        check("aligned_lock_at_64", 66'(lock_at), 66'd64);

        // Deferred slip: block 20 is bad and emitted with exactly 66 bits buffered.
        do_reset();
        gen_restart();
        bad_set[19] = 1'b1;
        for (int c = 0; c < 34; c++) step(1'b1);
        check("defer_block20_out", 66'(blk_cnt), 66'd20);
        check("defer_slip_pending", {50'd0, slip_count}, 66'd0);
        step(1'b1);
        check("defer_slip_applied", {50'd0, slip_count}, 66'd1);
        for (int c = 0; c < 10 && blk_cnt < 21; c++) step(1'b1);
        for (int i = 0; i < 66; i++) e[i] = sent_log[1321 + i];
        check("defer_one_bit_dropped", last_blk, e);

        // Offset stream: 13 junk bits ahead of aligned blocks.
        gen_restart();
        for (int i = 0; i < 13; i++) gen_q.push_back(1'($urandom));
        for (int i = 0; i < 300; i++) gen_block();
        off_stream = gen_q;
        off_blocks = src_blk;

        do_reset();
        gen_restart();
        gen_q = off_stream;
        for (int c = 0; c < 3000 && lock_at < 0; c++) step(1'b1);
        check("offset_locked", {65'd0, lock}, 66'd1);
        check("offset_slip_bound", {65'd0, (slip_count <= 16'd65)}, 66'd1);
        check("offset_slips", {50'd0, slips_at_lock}, 66'd13);
        if (lock_at > 0) check("offset_block_matches", last_blk, off_blocks[lock_at - 1]);
        else check("offset_block_matches", {34'd0, 32'(lock_at)}, 66'd1);
        slips_b   = slips_at_lock;
        lock_at_b = lock_at;
        for (int c = 0; c < 80; c++) step(1'b1);

        // Same offset stream with rx_ready low one cycle in three.
        do_reset();
        gen_restart();
        gen_q = off_stream;
        for (int c = 0; c < 5000 && lock_at < 0; c++) step((c % 3) != 2);
        check("gap_locked", {65'd0, lock}, 66'd1);
        check("gap_slips_match", {50'd0, slips_at_lock}, {50'd0, slips_b});
        check("gap_blocks_match", 66'(lock_at), 66'(lock_at_b));
        for (int c = 0; c < 60; c++) step((c % 3) != 2);

        // Reset while locked, then relock on a fresh aligned stream.
        do_reset();
        gen_restart();
        for (int c = 0; c < 400 && blk_cnt < 80; c++) step(1'b1);
        check("locked_before_reset", {65'd0, lock}, 66'd1);
        do_reset();
        gen_restart();
        for (int c = 0; c < 400 && blk_cnt < 70; c++) step(1'b1);
        check("relock_at_64", 66'(lock_at), 66'd64);
        check("relock_slips", {50'd0, slip_count}, 66'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
